// File: rtl/mem_pkg.sv
// Shared store-path definitions: op encodings, byte-lane masks and the packed write beat.
// Byte order is big-endian, so lane 0 is bits [31:24] and maps to be[3].
package mem_pkg;

    typedef enum logic [1:0] {
        ST_SB  = 2'b00,
        ST_SH  = 2'b01,
        ST_SW  = 2'b10,
        ST_RSV = 2'b11
    } st_op_e;

    localparam logic [3:0] BE_B0 = 4'b1000;
    localparam logic [3:0] BE_B1 = 4'b0100;
    localparam logic [3:0] BE_B2 = 4'b0010;
    localparam logic [3:0] BE_B3 = 4'b0001;
    localparam logic [3:0] BE_H0 = 4'b1100;
    localparam logic [3:0] BE_H2 = 4'b0011;
    localparam logic [3:0] BE_W  = 4'b1111;

    // Widest address a beat can carry; narrower ADDR_W uses the low bits.
    localparam int BEAT_ADDR_W = 32;

    typedef struct packed {
        logic [BEAT_ADDR_W-1:0] addr;
        logic [31:0]            wdata;
        logic [3:0]             be;
        logic                   err;
    } beat_t;

endpackage

// File: rtl/lane_pack.sv
// Combinational store lane placement: narrows the register operand and places it
// in its big-endian byte lanes, flagging misaligned or reserved stores.
module lane_pack
    import mem_pkg::*;
(
    input  logic [1:0]  op,
    input  logic [1:0]  lane,
    input  logic [31:0] data,
    output logic [31:0] wdata,
    output logic [3:0]  be,
    output logic        err
);

    always_comb begin
        wdata = '0;
        be    = '0;
        err   = 1'b0;
        case (st_op_e'(op))
            ST_SB: begin
                case (lane)
                    2'd0: begin wdata = {data[7:0], 24'h0};       be = BE_B0; end
                    2'd1: begin wdata = {8'h0, data[7:0], 16'h0}; be = BE_B1; end
                    2'd2: begin wdata = {16'h0, data[7:0], 8'h0}; be = BE_B2; end
                    default: begin wdata = {24'h0, data[7:0]};    be = BE_B3; end
                endcase
            end
            ST_SH: begin
                if (lane[0]) begin
                    err = 1'b1;
                end else if (!lane[1]) begin
                    wdata = {data[15:0], 16'h0};
                    be    = BE_H0;
                end else begin
                    wdata = {16'h0, data[15:0]};
                    be    = BE_H2;
                end
            end
            ST_SW: begin
                if (lane != 2'd0) begin
                    err = 1'b1;
                end else begin
                    wdata = data;
                    be    = BE_W;
                end
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/store_lane_packer.sv
// MEM-stage store aligner: lane-packs EX/MEM stores into data-memory write beats
// behind a registered output stage with a one-entry skid buffer.
module store_lane_packer
    import mem_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_op,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [31:0]       out_wdata,
    output logic [3:0]        out_be,
    output logic              out_err,
    output logic [CNT_W-1:0]  misalign_cnt
);

    beat_t            beat_in;
    beat_t            out_q;
    beat_t            skid_q;
    logic             out_valid_q;
    logic             skid_full_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      pk_wdata;
    logic [3:0]       pk_be;
    logic             pk_err;
    logic             in_fire;
    logic             out_load;

    lane_pack u_lane_pack (
        .op    (in_op),
        .lane  (in_addr[1:0]),
        .data  (in_data),
        .wdata (pk_wdata),
        .be    (pk_be),
        .err   (pk_err)
    );

    always_comb begin
        beat_in                = '0;
        beat_in.addr[ADDR_W-1:2] = in_addr[ADDR_W-1:2];
        beat_in.wdata          = pk_wdata;
        beat_in.be             = pk_be;
        beat_in.err            = pk_err;
    end

    // in_ready comes straight off the skid flag, so out_ready never reaches it combinationally.
    assign in_ready = !skid_full_q;
    assign in_fire  = in_valid && in_ready;
    assign out_load = !out_valid_q || out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            skid_q      <= '0;
            skid_full_q <= 1'b0;
        end else if (out_load) begin
            // A full skid blocks new input, so draining it never collides with an accept.
            if (skid_full_q) begin
                out_q       <= skid_q;
                out_valid_q <= 1'b1;
                skid_full_q <= 1'b0;
            end else if (in_fire) begin
                out_q       <= beat_in;
                out_valid_q <= 1'b1;
            end else begin
                out_valid_q <= 1'b0;
            end
        end else if (in_fire) begin
            skid_q      <= beat_in;
            skid_full_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (out_valid_q && out_ready && out_q.err && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign out_valid    = out_valid_q;
    assign out_addr     = out_q.addr[ADDR_W-1:0];
    assign out_wdata    = out_q.wdata;
    assign out_be       = out_q.be;
    assign out_err      = out_q.err;
    assign misalign_cnt = cnt_q;

endmodule

// File: tb/tb_store_lane_packer.sv
// Directed bench for store_lane_packer: lane placement, error beats, backpressure,
// counter saturation (second instance with CNT_W=2) and reset during a stall.
module tb_store_lane_packer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_addr;
    logic [31:0] out_wdata;
    logic [3:0]  out_be;
    logic        out_err;
    logic [7:0]  misalign_cnt;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [31:0] s_out_addr;
    logic [31:0] s_out_wdata;
    logic [3:0]  s_out_be;
    logic        s_out_err;
    logic [1:0]  s_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    store_lane_packer #(.ADDR_W(32), .CNT_W(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_addr(in_addr), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr),
        .out_wdata(out_wdata), .out_be(out_be), .out_err(out_err),
        .misalign_cnt(misalign_cnt)
    );

    store_lane_packer #(.ADDR_W(32), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_op(in_op),
        .in_addr(in_addr), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_addr(s_out_addr),
        .out_wdata(s_out_wdata), .out_be(s_out_be), .out_err(s_out_err),
        .misalign_cnt(s_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int NV = 12;
    logic [1:0]  v_op    [NV] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2};
    logic [31:0] v_addr  [NV] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h200, 32'h202,
                                  32'h204, 32'h301, 32'h302, 32'h300, 32'h400, 32'h401};
    logic [31:0] v_data  [NV] = '{32'h123456AB, 32'h123456AB, 32'h123456AB, 32'h123456AB,
                                  32'hCAFEBEEF, 32'hCAFEBEEF, 32'hCAFEBEEF, 32'hCAFEBEEF,
                                  32'hCAFEBEEF, 32'hCAFEBEEF, 32'h11111111, 32'h22222222};
    logic [31:0] e_wdata [NV] = '{32'hAB000000, 32'h00AB0000, 32'h0000AB00, 32'h000000AB,
                                  32'hBEEF0000, 32'h0000BEEF, 32'hCAFEBEEF, 32'h0,
                                  32'h0, 32'h0, 32'h0, 32'h0};
    logic [3:0]  e_be    [NV] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1100, 4'b0011,
                                  4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    logic        e_err   [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [31:0] e_addr  [NV] = '{32'h100, 32'h100, 32'h100, 32'h100, 32'h200, 32'h200,
                                  32'h204, 32'h300, 32'h300, 32'h300, 32'h400, 32'h400};

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data);
        in_valid = 1'b1;
        in_op    = op;
        in_addr  = addr;
        in_data  = data;
    endtask

    task automatic expect_beat(input int idx);
        check_val($sformatf("v%0d_valid", idx), out_valid, 1'b1);
        check_val($sformatf("v%0d_wdata", idx), out_wdata, e_wdata[idx]);
        check_val($sformatf("v%0d_be", idx),    out_be,    e_be[idx]);
        check_val($sformatf("v%0d_err", idx),   out_err,   e_err[idx]);
        check_val($sformatf("v%0d_addr", idx),  out_addr,  e_addr[idx]);
    endtask

    int          send_idx;
    int          rcv_idx;
    logic        prev_hold;
    logic [31:0] prev_wdata;
    logic [3:0]  prev_be;
    logic [31:0] prev_addr;
    logic        saw_not_ready;

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'd0;
        in_addr   = '0;
        in_data   = '0;
        out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_out_addr",  out_addr,  32'h0);
        check_val("rst_out_wdata", out_wdata, 32'h0);
        check_val("rst_out_be",    out_be,    4'h0);
        check_val("rst_out_err",   out_err,   1'b0);
        check_val("rst_cnt",       misalign_cnt, 8'h0);
        reset = 1'b1;
        @(negedge clk);
        check_val("rst_in_ready",  in_ready,  1'b1);

        // Back-to-back stream of directed vectors, out_ready held high
        for (int i = 0; i <= NV; i++) begin
            @(negedge clk);
            if (i > 0) expect_beat(i - 1);
            if (i == 11) begin
                check_val("cnt_after3",     misalign_cnt, 8'd3);
                check_val("cnt_sat_after3", s_cnt,        2'd3);
            end
            if (i < NV) drive(v_op[i], v_addr[i], v_data[i]);
            else        in_valid = 1'b0;
        end
        @(negedge clk);
        check_val("stream_idle",  out_valid,    1'b0);
        check_val("cnt_final",    misalign_cnt, 8'd5);
        check_val("cnt_sat_hold", s_cnt,        2'd3);

        // Backpressure: four SW beats, out_ready low for cycles 2-5
        send_idx      = 0;
        rcv_idx       = 0;
        prev_hold     = 1'b0;
        prev_wdata    = '0;
        prev_be       = '0;
        prev_addr     = '0;
        saw_not_ready = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (prev_hold) begin
                check_val("bp_stable_valid", out_valid, 1'b1);
                check_val("bp_stable_wdata", out_wdata, prev_wdata);
                check_val("bp_stable_be",    out_be,    prev_be);
                check_val("bp_stable_addr",  out_addr,  prev_addr);
            end
            out_ready = !(cyc >= 2 && cyc <= 5);
            if (send_idx < 4) drive(2'd2, 32'h500 + 32'(4 * send_idx), 32'(send_idx + 1));
            else              in_valid = 1'b0;
            if (!in_ready) saw_not_ready = 1'b1;
            if (in_valid && in_ready) send_idx++;
            if (out_valid && out_ready) begin
                check_val($sformatf("bp_order%0d", rcv_idx), out_wdata, 32'(rcv_idx + 1));
                rcv_idx++;
            end
            prev_hold  = out_valid && !out_ready;
            prev_wdata = out_wdata;
            prev_be    = out_be;
            prev_addr  = out_addr;
        end
        check_val("bp_in_ready_drop", saw_not_ready, 1'b1);
        check_val("bp_sent",          send_idx,      4);
        check_val("bp_received",      rcv_idx,       4);

        // Reset asserted mid-stall with output and skid both holding beats
        @(negedge clk);
        out_ready = 1'b0;
        drive(2'd2, 32'h600, 32'hA);
        @(negedge clk);
        drive(2'd2, 32'h604, 32'hB);
        @(negedge clk);
        in_valid = 1'b0;
        check_val("stall_in_ready",  in_ready,  1'b0);
        check_val("stall_out_valid", out_valid, 1'b1);
        check_val("stall_wdata",     out_wdata, 32'hA);
        reset = 1'b0;
        #2;
        check_val("mid_rst_out_valid", out_valid, 1'b0);
        check_val("mid_rst_out_be",    out_be,    4'h0);
        check_val("mid_rst_cnt",       misalign_cnt, 8'h0);
        #2;
        reset = 1'b1;
        @(negedge clk);
        check_val("post_rst_in_ready",  in_ready,  1'b1);
        check_val("post_rst_out_valid", out_valid, 1'b0);
        out_ready = 1'b1;
        @(negedge clk);
        check_val("post_rst_skid_gone", out_valid, 1'b0);
        check_val("post_rst_cnt_sat",   s_cnt,     2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
